// File: rtl/zliczanie_sekw.sv
// Sequential ones-counter: accepts {i_argA, i_argB} on a valid/ready handshake, counts set bits
// one per clock and presents a BITS-wide count plus carry on a result valid/ready handshake.
`timescale 1ns/1ps
module zliczanie_sekw #(
    parameter int unsigned BITS = 2,
    parameter int unsigned LEN  = BITS * 2
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_valid,
    output logic                   o_ready,
    input  logic signed [BITS-1:0] i_argA,
    input  logic signed [BITS-1:0] i_argB,
    output logic                   o_valid,
    input  logic                   i_ready,
    output logic [BITS-1:0]        o_result,
    output logic                   o_carry
);

    localparam int unsigned CW = $clog2(LEN + 1);
    localparam int unsigned IW = $clog2(LEN);
    // Common width so the result slice and carry reduction stay legal for any BITS/CW ratio.
    localparam int unsigned XW = (CW > BITS) ? CW : BITS;

    typedef enum logic [1:0] {
        StIdle,
        StCount,
        StDone
    } state_e;

    state_e          state_q, state_d;
    logic [LEN-1:0]  shift_q, shift_d;
    logic [CW-1:0]   acc_q, acc_d;
    logic [CW-1:0]   acc_next;
    logic [IW-1:0]   idx_q, idx_d;
    logic [BITS-1:0] result_q, result_d;
    logic            carry_q, carry_d;
    logic [XW-1:0]   acc_ext;
    logic            last_bit;

    assign acc_next = acc_q + CW'(shift_q[0]);
    assign acc_ext  = XW'(acc_next);
    assign last_bit = (idx_q == IW'(LEN - 1));

    always_comb begin
        state_d  = state_q;
        shift_d  = shift_q;
        acc_d    = acc_q;
        idx_d    = idx_q;
        result_d = result_q;
        carry_d  = carry_q;
        unique case (state_q)
            StIdle: begin
                if (i_valid) begin
                    shift_d = LEN'({i_argA, i_argB});
                    acc_d   = '0;
                    idx_d   = '0;
                    state_d = StCount;
                end
            end
            StCount: begin
                acc_d   = acc_next;
                shift_d = shift_q >> 1;
                idx_d   = idx_q + IW'(1);
                if (last_bit) begin
                    state_d  = StDone;
                    result_d = acc_ext[BITS-1:0];
                    carry_d  = |(acc_ext >> BITS);
                end
            end
            StDone: begin
                if (i_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q  <= StIdle;
            shift_q  <= '0;
            acc_q    <= '0;
            idx_q    <= '0;
            result_q <= '0;
            carry_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            shift_q  <= shift_d;
            acc_q    <= acc_d;
            idx_q    <= idx_d;
            result_q <= result_d;
            carry_q  <= carry_d;
        end
    end

    // Handshake flags decode only the state register, so no input reaches an output combinationally.
    assign o_ready  = (state_q == StIdle);
    assign o_valid  = (state_q == StDone);
    assign o_result = result_q;
    assign o_carry  = carry_q;

    a_hold_result : assert property (@(posedge i_clk) disable iff (!i_rst_n)
        (o_valid && !i_ready) |=> (o_valid && $stable(o_result) && $stable(o_carry)));

endmodule

// File: tb/tb_zliczanie_sekw.sv
// Directed self-checking bench for zliczanie_sekw with a BITS=2 and a BITS=4 instance.
`timescale 1ns/1ps
module tb_zliczanie_sekw;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic              v2 = 1'b0, ir2 = 1'b0, rdy2, ov2, car2;
    logic signed [1:0] a2 = '0, b2 = '0;
    logic [1:0]        res2;
    logic              v4 = 1'b0, ir4 = 1'b0, rdy4, ov4, car4;
    logic signed [3:0] a4 = '0, b4 = '0;
    logic [3:0]        res4;

    int checks = 0;
    int passes = 0;

    zliczanie_sekw #(.BITS(2)) dut2 (
        .i_clk(clk), .i_rst_n(rst_n), .i_valid(v2), .o_ready(rdy2), .i_argA(a2), .i_argB(b2),
        .o_valid(ov2), .i_ready(ir2), .o_result(res2), .o_carry(car2)
    );

    zliczanie_sekw #(.BITS(4)) dut4 (
        .i_clk(clk), .i_rst_n(rst_n), .i_valid(v4), .o_ready(rdy4), .i_argA(a4), .i_argB(b4),
        .o_valid(ov4), .i_ready(ir4), .o_result(res4), .o_carry(car4)
    );

    // Runs one operation from a negedge; stall>0 holds i_ready low that many valid cycles
    // and drives a noisy i_valid/operand stream while busy.
    task automatic do_op(input bit wide, input logic [3:0] a, input logic [3:0] b,
                         input int stall, output int lat, output int vcnt, output int rlow,
                         output logic [3:0] res, output logic car, output bit unstable);
        int left;
        lat = -1; vcnt = 0; rlow = 0; res = '0; car = 1'b0; unstable = 1'b0; left = stall;
        for (int w = 0; w < 30 && !(wide ? rdy4 : rdy2); w++) @(negedge clk);
        if (wide) begin v4 = 1'b1; a4 = a; b4 = b; ir4 = (stall == 0); end
        else begin v2 = 1'b1; a2 = a[1:0]; b2 = b[1:0]; ir2 = (stall == 0); end
        @(posedge clk);
        #1;
        v2 = 1'b0; v4 = 1'b0;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            if (wide ? ov4 : ov2) begin
                if (lat < 0) begin
                    lat = n - 1;
                    res = wide ? res4 : {2'b00, res2};
                    car = wide ? car4 : car2;
                end else if (res !== (wide ? res4 : {2'b00, res2}) || car !== (wide ? car4 : car2))
                    unstable = 1'b1;
                vcnt++;
                if (left > 0) begin
                    left--;
                    if (left == 0) begin ir2 = 1'b1; ir4 = 1'b1; end
                end
            end
            if (wide ? rdy4 : rdy2) break;
            rlow++;
            if (stall > 0) begin
                if (wide) begin v4 = n[0]; a4 = n[3:0]; b4 = ~n[3:0]; end
                else begin v2 = n[0]; a2 = n[1:0]; b2 = ~n[1:0]; end
            end
        end
        v2 = 1'b0; v4 = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        checks++; if (rdy2 !== 1'b1) $display("FAIL reset_ready2: got %b want 1", rdy2); else passes++;
        checks++; if (ov2 !== 1'b0) $display("FAIL reset_valid2: got %b want 0", ov2); else passes++;
        checks++; if (res2 !== 2'd0) $display("FAIL reset_result2: got %0d want 0", res2); else passes++;
        checks++; if (car2 !== 1'b0) $display("FAIL reset_carry2: got %b want 0", car2); else passes++;
        checks++; if (rdy4 !== 1'b1) $display("FAIL reset_ready4: got %b want 1", rdy4); else passes++;
        checks++; if (ov4 !== 1'b0) $display("FAIL reset_valid4: got %b want 0", ov4); else passes++;
        checks++; if (res4 !== 4'd0) $display("FAIL reset_result4: got %0d want 0", res4); else passes++;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic();
        int lat, vcnt, rlow; logic [3:0] res; logic car; bit unst;
        do_op(1'b0, 4'b0011, 4'b0001, 0, lat, vcnt, rlow, res, car, unst);
        checks++; if (res !== 4'd3) $display("FAIL basic_result: got %0d want 3", res); else passes++;
        checks++; if (car !== 1'b0) $display("FAIL basic_carry: got %b want 0", car); else passes++;
        checks++; if (lat != 4) $display("FAIL basic_latency: got %0d want 4", lat); else passes++;
        checks++; if (vcnt != 1) $display("FAIL basic_valid_len: got %0d want 1", vcnt); else passes++;
        checks++; if (rlow != 5) $display("FAIL basic_ready_low: got %0d want 5", rlow); else passes++;
        @(negedge clk);
        checks++; if (res2 !== 2'd3) $display("FAIL basic_result_held: got %0d want 3", res2); else passes++;
    endtask

    task automatic test_carry();
        int lat, vcnt, rlow; logic [3:0] res; logic car; bit unst;
        do_op(1'b0, 4'b0011, 4'b0011, 0, lat, vcnt, rlow, res, car, unst);
        checks++; if (res !== 4'd0) $display("FAIL carry_result: got %0d want 0", res); else passes++;
        checks++; if (car !== 1'b1) $display("FAIL carry_carry: got %b want 1", car); else passes++;
        do_op(1'b0, 4'b0000, 4'b0000, 0, lat, vcnt, rlow, res, car, unst);
        checks++; if (res !== 4'd0) $display("FAIL zero_result: got %0d want 0", res); else passes++;
        checks++; if (car !== 1'b0) $display("FAIL zero_carry: got %b want 0", car); else passes++;
    endtask

    task automatic test_backpressure();
        int lat, vcnt, rlow; logic [3:0] res; logic car; bit unst;
        do_op(1'b0, 4'b0010, 4'b0001, 6, lat, vcnt, rlow, res, car, unst);
        checks++; if (res !== 4'd2) $display("FAIL bp_result: got %0d want 2", res); else passes++;
        checks++; if (lat != 4) $display("FAIL bp_latency: got %0d want 4", lat); else passes++;
        checks++; if (vcnt != 6) $display("FAIL bp_valid_len: got %0d want 6", vcnt); else passes++;
        checks++; if (rlow != 10) $display("FAIL bp_ready_low: got %0d want 10", rlow); else passes++;
        checks++; if (unst !== 1'b0) $display("FAIL bp_stable: got %b want 0", unst); else passes++;
    endtask

    task automatic test_reset_mid_count();
        int lat, vcnt, rlow; logic [3:0] res; logic car; bit unst;
        for (int w = 0; w < 30 && !rdy2; w++) @(negedge clk);
        v2 = 1'b1; a2 = 2'b11; b2 = 2'b11; ir2 = 1'b1;
        @(posedge clk);
        #1 v2 = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #3;
        checks++; if (rdy2 !== 1'b0) $display("FAIL rst_busy_before: got %b want 0", rdy2); else passes++;
        rst_n = 1'b0;
        #1;
        checks++; if (rdy2 !== 1'b1) $display("FAIL rst_ready: got %b want 1", rdy2); else passes++;
        checks++; if (ov2 !== 1'b0) $display("FAIL rst_valid: got %b want 0", ov2); else passes++;
        checks++; if (res2 !== 2'd0) $display("FAIL rst_result: got %0d want 0", res2); else passes++;
        checks++; if (car2 !== 1'b0) $display("FAIL rst_carry: got %b want 0", car2); else passes++;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        do_op(1'b0, 4'b0001, 4'b0000, 0, lat, vcnt, rlow, res, car, unst);
        checks++; if (res !== 4'd1) $display("FAIL rst_after_result: got %0d want 1", res); else passes++;
        checks++; if (lat != 4) $display("FAIL rst_after_latency: got %0d want 4", lat); else passes++;
    endtask

    task automatic test_bits4();
        int lat, vcnt, rlow; logic [3:0] res; logic car; bit unst;
        do_op(1'b1, 4'hF, 4'hA, 0, lat, vcnt, rlow, res, car, unst);
        checks++; if (res !== 4'd6) $display("FAIL b4_result: got %0d want 6", res); else passes++;
        checks++; if (car !== 1'b0) $display("FAIL b4_carry: got %b want 0", car); else passes++;
        checks++; if (lat != 8) $display("FAIL b4_latency: got %0d want 8", lat); else passes++;
        checks++; if (rlow != 9) $display("FAIL b4_ready_low: got %0d want 9", rlow); else passes++;
        do_op(1'b1, 4'hF, 4'hF, 0, lat, vcnt, rlow, res, car, unst);
        checks++; if (res !== 4'd8) $display("FAIL b4_full_result: got %0d want 8", res); else passes++;
        checks++; if (car !== 1'b0) $display("FAIL b4_full_carry: got %b want 0", car); else passes++;
    endtask

    task automatic test_back_to_back();
        logic [1:0] pa [3];
        logic [1:0] pb [3];
        logic [1:0] er [3];
        logic       ec [3];
        logic [1:0] gr [3];
        logic       gc [3];
        int acc_at [3];
        int nacc, nres;
        logic prev_rdy;
        pa = '{2'b01, 2'b11, 2'b11};
        pb = '{2'b10, 2'b10, 2'b11};
        er = '{2'd2, 2'd3, 2'd0};
        ec = '{1'b0, 1'b0, 1'b1};
        gr = '{2'd0, 2'd0, 2'd0};
        gc = '{1'b0, 1'b0, 1'b0};
        acc_at = '{0, 0, 0};
        nacc = 0; nres = 0;
        for (int w = 0; w < 30 && !rdy2; w++) @(negedge clk);
        ir2 = 1'b1; v2 = 1'b1; a2 = pa[0]; b2 = pb[0];
        prev_rdy = rdy2;
        for (int n = 1; n <= 60; n++) begin
            @(negedge clk);
            if (prev_rdy && !rdy2) begin
                if (nacc < 3) acc_at[nacc] = n;
                nacc++;
                if (nacc < 3) begin a2 = pa[nacc]; b2 = pb[nacc]; end
                else v2 = 1'b0;
            end
            if (ov2) begin
                if (nres < 3) begin gr[nres] = res2; gc[nres] = car2; end
                nres++;
            end
            prev_rdy = rdy2;
            if (nres >= 3 && rdy2) break;
        end
        v2 = 1'b0;
        checks++; if (nacc != 3) $display("FAIL b2b_accepts: got %0d want 3", nacc); else passes++;
        checks++; if (nres != 3) $display("FAIL b2b_results: got %0d want 3", nres); else passes++;
        checks++;
        if (acc_at[1] - acc_at[0] != 6) $display("FAIL b2b_gap01: got %0d want 6", acc_at[1] - acc_at[0]);
        else passes++;
        checks++;
        if (acc_at[2] - acc_at[1] != 6) $display("FAIL b2b_gap12: got %0d want 6", acc_at[2] - acc_at[1]);
        else passes++;
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (gr[k] !== er[k]) $display("FAIL b2b_result%0d: got %0d want %0d", k, gr[k], er[k]);
            else passes++;
            checks++;
            if (gc[k] !== ec[k]) $display("FAIL b2b_carry%0d: got %b want %b", k, gc[k], ec[k]);
            else passes++;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_basic();
        test_carry();
        test_backpressure();
        test_reset_mid_count();
        test_bits4();
        test_back_to_back();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
